dbus_responder: RTL
===================

Name: dbus_responder

Overview:
- Responder (slave) end of the CPU data-memory port. It services the CPU's rd/wr strobes, read/write addresses and write data, and returns read data with fixed one-cycle latency.
- Addresses 0x00-0xEF map to a synchronous data RAM.
- Addresses 0xF0-0xFF map to memory-mapped I/O: an output FIFO drained by a valid/ready sink, a status register, a 32-bit cycle counter and a scratch register.
- Sits beside the CPU in the top level, in place of a bare RAM.

Parameters:
- AWIDTH, 8, data address width.
- DWIDTH, 16, data word width.
- FIFO_DEPTH, 8, output FIFO entries; power of 2, 2..16.
- IO_BASE, 8'hF0, first I/O address; the I/O region is IO_BASE..2^AWIDTH-1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- i_rd  in  1  read strobe from CPU.
- i_raddr  in  AWIDTH  read address.
- i_wr  in  1  write strobe from CPU.
- i_waddr  in  AWIDTH  write address.
- i_wdata  in  DWIDTH  write data.
- o_rdata  out  DWIDTH  read data; valid the cycle after i_rd.
- o_out_valid  out  1  FIFO head available.
- o_out_data  out  DWIDTH  FIFO head word.
- i_out_ready  in  1  sink accepts head; pop on valid&&ready.
- o_irq  out  1  level: FIFO overflow sticky bit set.

Behaviour:
- Reset (rst=1 at an edge):
  - o_rdata=0, FIFO empty, o_out_valid=0, o_out_data=0.
  - Overflow sticky=0, o_irq=0, cycle counter=0, HI snapshot=0, scratch=0.
  - RAM contents are not cleared.
  - Reset during an in-flight read discards the read: o_rdata=0 next cycle.
- Read latency:
  - i_rd at edge N loads o_rdata at edge N+1 with data for i_raddr sampled at N.
  - With i_rd=0, o_rdata holds its last value.
- Simultaneous read and write, same address, same cycle: read returns old data (read-before-write). This applies to RAM and I/O alike.
- RAM: addresses below IO_BASE, single cycle write.
- I/O map (offsets from IO_BASE); undefined offsets read 0 and ignore writes:
  - +0 OUT_DATA:
    - W: push i_wdata.
    - R: 0.
  - +1 STATUS:
    - R: [0] full, [1] empty, [7:4] occupancy (0..FIFO_DEPTH, saturating at 15), [15] overflow sticky, other bits 0.
    - W: writing 1 to bit15 clears overflow; other bits ignored.
  - +2 CYC_LO:
    - R: counter[15:0] as sampled at the request edge.
    - Also latches counter[31:16] of the same sample into the HI snapshot.
  - +3 CYC_HI: R: the HI snapshot. Counter bits are read-only.
  - +4 SCRATCH: R/W plain register.
- Cycle counter:
  - Increments every non-reset cycle.
  - Wraps 32'hFFFFFFFF -> 0.
  - A read of HI without a prior LO read returns the stale snapshot.
- FIFO handshake:
  - Pop occurs when o_out_valid && i_out_ready.
  - o_out_data is registered and is the head; it must hold stable while valid && !ready.
  - Push to an empty FIFO: o_out_valid=1 on the next cycle.
  - Push while full with no pop in the same cycle: word dropped, overflow set, contents unchanged.
  - Push while full with a pop in the same cycle: push accepted, occupancy unchanged, no overflow.
  - Push and pop simultaneously when not full or empty: occupancy unchanged.
  - Pop of the last entry with no push: o_out_valid=0 next cycle.
  - Overflow set and a software clear in the same cycle: set wins.
  - Occupancy never exceeds FIFO_DEPTH; pointers wrap modulo FIFO_DEPTH.
- No state machine beyond the FIFO pointer/count logic; all outputs registered except o_irq, which is driven directly from the overflow flop.

Decomposition:
- Shared package dbus_pkg: I/O offset constants (OFF_OUT_DATA=0, OFF_STATUS=1, OFF_CYC_LO=2, OFF_CYC_HI=3, OFF_SCRATCH=4) and STATUS bit positions (ST_FULL=0, ST_EMPTY=1, ST_CNT_LSB=4, ST_OVF=15).
- One natural sub-module: sync_fifo.
  - Parameters: DWIDTH, DEPTH.
  - Function: push/pop, full/empty/count, registered head, same-cycle push-on-full-with-pop rule.
- The remaining RAM, decode and counter logic lives in dbus_responder.

Test Plan:
- RAM round trip: write 16'hBEEF to 0x10, then read 0x10 → o_rdata=16'hBEEF exactly one cycle after i_rd. Same-cycle rd/wr 0x10 with 16'h1234 → read returns 16'hBEEF; the next read returns 16'h1234.
- FIFO fill and overflow: i_out_ready=0, push 1..9 (FIFO_DEPTH=8).
  - STATUS reads 16'h8081 (full, count 8, overflow) and o_irq=1.
  - Drain with ready=1 yields 1..8 in order, then valid=0.
  - Write 16'h8000 to STATUS → o_irq=0.
- Full push with simultaneous pop: FIFO full, ready=1, push 16'hAA in the same cycle → no overflow, count stays 8, 16'hAA emerges last.
- Backpressure: valid=1, ready=0 for 5 cycles → o_out_data constant; ready=1 for one cycle → exactly one pop.
- Counter snapshot: force counter to 32'h0001FFFF.
  - Read CYC_LO → 16'hFFFF.
  - Next read CYC_HI → 16'h0001, although the live counter is now 32'h00020000 or later.
  - Wrap from 32'hFFFFFFFF → 0.
- Reset mid-operation: rst=1 in the cycle after i_rd to SCRATCH=16'h5A5A → o_rdata=0, FIFO empty, counter 0, SCRATCH reads 0; RAM word at 0x10 still 16'h1234.

Source files
------------

// File: rtl/dbus_pkg.sv
// Shared constants for the data-bus responder: I/O register offsets and
// STATUS register bit positions.
package dbus_pkg;

    localparam int unsigned OFF_OUT_DATA = 0;
    localparam int unsigned OFF_STATUS   = 1;
    localparam int unsigned OFF_CYC_LO   = 2;
    localparam int unsigned OFF_CYC_HI   = 3;
    localparam int unsigned OFF_SCRATCH  = 4;

    localparam int unsigned ST_FULL    = 0;
    localparam int unsigned ST_EMPTY   = 1;
    localparam int unsigned ST_CNT_LSB = 4;
    localparam int unsigned ST_CNT_W   = 4;
    localparam int unsigned ST_OVF     = 15;

    localparam int unsigned CNT_W = 32;

endpackage

// File: rtl/dbus_responder_sync_fifo.sv
// Output FIFO with a registered head word; a push into a full FIFO is only
// accepted when the head is popped in the same cycle.
module sync_fifo #(
    parameter int DWIDTH = 16,
    parameter int DEPTH  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [DWIDTH-1:0]          push_data,
    input  logic                       pop_ready,
    output logic                       out_valid,
    output logic [DWIDTH-1:0]          out_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       drop
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr, rd_next;
    logic [CW-1:0]     count_next;
    logic [DWIDTH-1:0] head_next;
    logic              do_push, do_pop;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    always_comb begin
        do_pop     = out_valid && pop_ready;
        do_push    = push && (!full || do_pop);
        drop       = push && full && !do_pop;
        rd_next    = rd_ptr + PW'(do_pop);
        count_next = count + CW'(do_push) - CW'(do_pop);
        head_next  = out_data;
        // The slot being written this cycle becomes the head when the FIFO
        // would otherwise be empty, so bypass the storage array.
        if (count_next != '0)
            head_next = (do_push && wr_ptr == rd_next) ? push_data : mem[rd_next];
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            wr_ptr    <= wr_ptr + PW'(do_push);
            rd_ptr    <= rd_next;
            count     <= count_next;
            out_valid <= (count_next != '0);
            out_data  <= head_next;
        end
    end

endmodule

// File: rtl/dbus_responder.sv
// Responder end of the CPU data port: RAM below IO_BASE, memory-mapped output
// FIFO, status, free-running cycle counter and scratch register above it.
module dbus_responder
    import dbus_pkg::*;
#(
    parameter int          AWIDTH     = 8,
    parameter int          DWIDTH     = 16,
    parameter int          FIFO_DEPTH = 8,
    parameter int unsigned IO_BASE    = 'hF0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_rd,
    input  logic [AWIDTH-1:0] i_raddr,
    input  logic              i_wr,
    input  logic [AWIDTH-1:0] i_waddr,
    input  logic [DWIDTH-1:0] i_wdata,
    output logic [DWIDTH-1:0] o_rdata,
    output logic              o_out_valid,
    output logic [DWIDTH-1:0] o_out_data,
    input  logic              i_out_ready,
    output logic              o_irq
);

    localparam logic [AWIDTH-1:0] IO_BASE_A = AWIDTH'(IO_BASE);
    localparam int                CW        = $clog2(FIFO_DEPTH + 1);

    logic [DWIDTH-1:0] ram [IO_BASE];
    logic [CNT_W-1:0]  cyc_cnt;
    logic [15:0]       cyc_hi_snap;
    logic [DWIDTH-1:0] scratch;
    logic              ovf;

    logic              r_io, w_io;
    logic [AWIDTH-1:0] roff, woff;
    logic              ram_we, push, ovf_clr, scratch_we, snap_ld;
    logic [DWIDTH-1:0] status, rd_mux;
    logic [ST_CNT_W-1:0] occ;

    logic          fifo_full, fifo_empty, fifo_drop;
    logic [CW-1:0] fifo_count;

    assign r_io = (i_raddr >= IO_BASE_A);
    assign w_io = (i_waddr >= IO_BASE_A);
    assign roff = i_raddr - IO_BASE_A;
    assign woff = i_waddr - IO_BASE_A;

    assign ram_we     = i_wr && !w_io;
    assign push       = i_wr && w_io && (woff == AWIDTH'(OFF_OUT_DATA));
    assign ovf_clr    = i_wr && w_io && (woff == AWIDTH'(OFF_STATUS)) && i_wdata[ST_OVF];
    assign scratch_we = i_wr && w_io && (woff == AWIDTH'(OFF_SCRATCH));
    assign snap_ld    = i_rd && r_io && (roff == AWIDTH'(OFF_CYC_LO));

    sync_fifo #(
        .DWIDTH (DWIDTH),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (i_wdata),
        .pop_ready (i_out_ready),
        .out_valid (o_out_valid),
        .out_data  (o_out_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .drop      (fifo_drop)
    );

    always_comb begin
        occ = (int'(fifo_count) > 15) ? ST_CNT_W'(15) : ST_CNT_W'(fifo_count);
        status                         = '0;
        status[ST_FULL]                = fifo_full;
        status[ST_EMPTY]               = fifo_empty;
        status[ST_CNT_LSB +: ST_CNT_W] = occ;
        status[ST_OVF]                 = ovf;
    end

    // All read sources are sampled before this edge's writes land, which gives
    // read-before-write for RAM and I/O alike.
    always_comb begin
        rd_mux = '0;
        if (!r_io) begin
            rd_mux = ram[i_raddr];
        end else begin
            case (roff)
                AWIDTH'(OFF_STATUS):  rd_mux = status;
                AWIDTH'(OFF_CYC_LO):  rd_mux = DWIDTH'(cyc_cnt[15:0]);
                AWIDTH'(OFF_CYC_HI):  rd_mux = DWIDTH'(cyc_hi_snap);
                AWIDTH'(OFF_SCRATCH): rd_mux = scratch;
                default:              rd_mux = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we)
            ram[i_waddr] <= i_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_rdata     <= '0;
            cyc_cnt     <= '0;
            cyc_hi_snap <= '0;
            scratch     <= '0;
            ovf         <= 1'b0;
        end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
            if (i_rd)
                o_rdata <= rd_mux;
            if (snap_ld)
                cyc_hi_snap <= cyc_cnt[31:16];
            if (scratch_we)
                scratch <= i_wdata;
            // A new overflow in the same cycle as a software clear wins.
            if (fifo_drop)
                ovf <= 1'b1;
            else if (ovf_clr)
                ovf <= 1'b0;
        end
    end

    assign o_irq = ovf;

endmodule
